// File: rtl/fifo_rd_pkg.sv
// Shared types for the FIFO read-side burst consumer.
// State encoding is fixed so debug tooling can decode the exposed state bits.
package fifo_rd_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_FLUSH = 2'd2,
    ST_WAIT  = 2'd3
  } state_e;

endpackage

// File: rtl/out_skid_buf.sv
// Two-entry output buffer between the FIFO read port and the downstream stream.
// A push and a pop in the same cycle both take effect, leaving occupancy unchanged.
module out_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              pop_o,
  output logic [1:0]        occ_o
);

  logic [DATA_W-1:0] mem_q [2];
  logic              rd_ptr_q;
  logic              wr_ptr_q;
  logic [1:0]        occ_q;

  assign valid_o = (occ_q != 2'd0);
  assign pop_o   = valid_o && ready_i;
  assign data_o  = mem_q[rd_ptr_q];
  assign occ_o   = occ_q;

  // The issuing side guarantees a push never arrives while both entries are held.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_o) rd_ptr_q <= ~rd_ptr_q;
      case ({push_i, pop_o})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// Read-domain consumer of the async byte FIFO: threshold bursts, timeout flushes,
// and a 2-entry valid/ready output stage that never lets the FIFO underflow.
module fifo_burst_reader
  import fifo_rd_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BURST_LEN = 16,
  parameter int TIMEOUT   = 64
) (
  input  logic              clk_r,
  input  logic              rst,
  input  logic [DATA_W-1:0] buf_out,
  input  logic              buf_empty,
  input  logic              thresh_out,
  input  logic              uf_check,
  output logic              rd_en,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              burst_active,
  output logic [7:0]        burst_count,
  output logic              uf_err,
  output logic [1:0]        dbg_state
);

  // Downstream handshake: a beat transfers on any rising clk_r edge where
  // m_valid and m_ready are both high; while m_ready is low, m_data and
  // m_valid hold their values. m_valid never depends on m_ready.

  localparam logic [7:0]  LAST_ISSUE = 8'(BURST_LEN - 1);
  localparam logic [15:0] IDLE_LIMIT = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  issue_cnt_q, issue_cnt_d;
  logic [15:0] idle_cnt_q, idle_cnt_d;
  logic [7:0]  burst_cnt_q;
  logic        burst_done;
  logic        inflight_q;
  logic        uf_err_q;
  logic [1:0]  occ;
  logic        pop;
  logic        has_room;
  logic        issuing;
  logic        last_issue;

  // Room exists when buffered + in-flight bytes, less this cycle's pop, stay below 2.
  assign has_room   = ({1'b0, occ} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});
  assign issuing    = (state_q == ST_BURST) || (state_q == ST_FLUSH);
  assign rd_en      = issuing && !buf_empty && has_room;
  assign last_issue = rd_en && (issue_cnt_q == LAST_ISSUE);

  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    idle_cnt_d  = '0;
    burst_done  = 1'b0;
    if (rd_en) issue_cnt_d = issue_cnt_q + 8'd1;
    case (state_q)
      ST_IDLE: begin
        if (thresh_out) begin
          state_d     = ST_BURST;
          issue_cnt_d = '0;
        end else if (!buf_empty) begin
          if (idle_cnt_q == IDLE_LIMIT) begin
            state_d     = ST_FLUSH;
            issue_cnt_d = '0;
          end else begin
            idle_cnt_d = idle_cnt_q + 16'd1;
          end
        end
      end
      ST_BURST: if (last_issue) state_d = ST_WAIT;
      ST_FLUSH: if (buf_empty || last_issue) state_d = ST_WAIT;
      ST_WAIT: begin
        if (!inflight_q && (occ == 2'd0)) begin
          state_d    = ST_IDLE;
          burst_done = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_r or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      issue_cnt_q <= '0;
      idle_cnt_q  <= '0;
      burst_cnt_q <= '0;
      inflight_q  <= 1'b0;
      uf_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      inflight_q  <= rd_en;
      uf_err_q    <= uf_err_q | uf_check;
      if (burst_done) burst_cnt_q <= burst_cnt_q + 8'd1;
    end
  end

  // The FIFO presents read data one cycle after rd_en, so the in-flight flag is the push.
  out_skid_buf #(
    .DATA_W(DATA_W)
  ) u_out_buf (
    .clk_i       (clk_r),
    .rst_ni      (rst),
    .push_i      (inflight_q),
    .push_data_i (buf_out),
    .ready_i     (m_ready),
    .valid_o     (m_valid),
    .data_o      (m_data),
    .pop_o       (pop),
    .occ_o       (occ)
  );

  assign burst_active = (state_q != ST_IDLE);
  assign burst_count  = burst_cnt_q;
  assign uf_err       = uf_err_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: a queue-based FIFO model feeds the DUT and an
// expected-byte queue checks the downstream stream order and buffer bound.
module tb_fifo_burst_reader;

  localparam int DW = 8;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BURST = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  logic          clk_r      = 1'b0;
  logic          rst        = 1'b0;
  logic [DW-1:0] buf_out    = '0;
  logic          buf_empty  = 1'b1;
  logic          thresh_out = 1'b0;
  logic          uf_check   = 1'b0;
  logic          m_ready    = 1'b0;
  logic          rd_en;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          burst_active;
  logic [7:0]    burst_count;
  logic          uf_err;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] wr_pend[$];
  logic [DW-1:0] exp_q[$];

  int   cyc = 0;
  int   rd_cnt = 0;
  int   n_out = 0;
  int   first_rd = 0;
  int   last_rd = 0;
  int   last_mv = 0;
  bit   first_seen = 1'b0;
  logic rd_en_s = 1'b0;

  fifo_burst_reader #(
    .DATA_W    (DW),
    .BURST_LEN (16),
    .TIMEOUT   (64)
  ) dut (
    .clk_r        (clk_r),
    .rst          (rst),
    .buf_out      (buf_out),
    .buf_empty    (buf_empty),
    .thresh_out   (thresh_out),
    .uf_check     (uf_check),
    .rd_en        (rd_en),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .burst_active (burst_active),
    .burst_count  (burst_count),
    .uf_err       (uf_err),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_r = ~clk_r;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- FIFO model ----------------
  // A read strobe seen in a cycle pops the head onto buf_out at the next edge.
  always @(posedge clk_r) begin
    if (rst && rd_en_s && fifo_q.size() > 0) begin
      buf_out <= fifo_q[0];
      exp_q.push_back(fifo_q[0]);
      void'(fifo_q.pop_front());
    end
    while (wr_pend.size() > 0) fifo_q.push_back(wr_pend.pop_front());
    buf_empty <= (fifo_q.size() == 0);
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk_r) begin
    if (!rst) begin
      rd_en_s = 1'b0;
    end else begin
      cyc++;
      rd_en_s = rd_en;
      if (rd_en) begin
        n_checks++;
        if (buf_empty) begin
          n_fail++;
          $display("FAIL rd_while_empty: rd_en=1 buf_empty=%0b, required buf_empty=0", buf_empty);
        end
        if (!first_seen) begin
          first_seen = 1'b1;
          first_rd   = cyc;
        end
        last_rd = cyc;
        rd_cnt++;
      end
      n_checks++;
      if (exp_q.size() > 2) begin
        n_fail++;
        $display("FAIL buffer_bound: occ+inflight=%0d, required <= 2", exp_q.size());
      end
      if (m_valid) last_mv = cyc;
      if (m_valid && m_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_beat: m_data=%0h with nothing read, required no beat", m_data);
        end else begin
          if (m_data !== exp_q[0]) begin
            n_fail++;
            $display("FAIL stream_data: m_data=%0h, required %0h", m_data, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
        n_out++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_r);
    #1;
  endtask

  task automatic push_bytes(input int n);
    for (int i = 0; i < n; i++) wr_pend.push_back(DW'($urandom_range(0, 255)));
  endtask

  task automatic wait_state(input logic [1:0] s, input int max_cyc);
    int k;
    k = 0;
    while (dbg_state !== s && k < max_cyc) begin
      tick();
      k++;
    end
  endtask

  task automatic clear_stats();
    rd_cnt     = 0;
    n_out      = 0;
    first_seen = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (rd_en !== 1'b0 || m_valid !== 1'b0 || burst_active !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: rd_en=%0b m_valid=%0b burst_active=%0b, required 0 0 0", rd_en, m_valid, burst_active);
    end
    n_checks++;
    if (m_data !== 8'h00 || burst_count !== 8'd0 || uf_err !== 1'b0 || dbg_state !== S_IDLE) begin
      n_fail++;
      $display("FAIL reset_regs: m_data=%0h count=%0d uf_err=%0b state=%0d, required 0 0 0 0", m_data, burst_count, uf_err, dbg_state);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_threshold_burst();
    clear_stats();
    m_ready = 1'b1;
    push_bytes(20);
    thresh_out = 1'b1;
    tick();
    n_checks++;
    if (dbg_state !== S_BURST || rd_en !== 1'b1 || m_valid !== 1'b0 || burst_active !== 1'b1) begin
      n_fail++;
      $display("FAIL burst_start: state=%0d rd_en=%0b m_valid=%0b active=%0b, required 1 1 0 1", dbg_state, rd_en, m_valid, burst_active);
    end
    thresh_out = 1'b0;
    tick();
    n_checks++;
    if (m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_early: m_valid=%0b one cycle after first read, required 0", m_valid);
    end
    tick();
    n_checks++;
    if (m_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL latency: m_valid=%0b two cycles after first read, required 1", m_valid);
    end
    wait_state(S_IDLE, 60);
    n_checks++;
    if (dbg_state !== S_IDLE || burst_count !== 8'd1) begin
      n_fail++;
      $display("FAIL burst_done: state=%0d count=%0d, required 0 1", dbg_state, burst_count);
    end
    n_checks++;
    if (rd_cnt !== 16 || (last_rd - first_rd + 1) !== 16 || n_out !== 16) begin
      n_fail++;
      $display("FAIL burst_reads: reads=%0d span=%0d out=%0d, required 16 16 16", rd_cnt, last_rd - first_rd + 1, n_out);
    end
    n_checks++;
    if ((last_mv + 1 - first_rd) !== 18) begin
      n_fail++;
      $display("FAIL burst_duration: %0d cycles, required 18", last_mv + 1 - first_rd);
    end
    // Four bytes remain below threshold and must leave via a timeout flush.
    wait_state(S_FLUSH, 80);
    wait_state(S_IDLE, 30);
    n_checks++;
    if (burst_count !== 8'd2 || rd_cnt !== 20 || fifo_q.size() !== 0 || n_out !== 20) begin
      n_fail++;
      $display("FAIL leftover_flush: count=%0d reads=%0d fifo=%0d out=%0d, required 2 20 0 20", burst_count, rd_cnt, fifo_q.size(), n_out);
    end
  endtask

  task automatic test_timeout_flush();
    int k;
    clear_stats();
    m_ready = 1'b1;
    push_bytes(3);
    tick();
    k = 0;
    while (dbg_state !== S_FLUSH && k < 200) begin
      tick();
      k++;
    end
    n_checks++;
    if (k !== 64) begin
      n_fail++;
      $display("FAIL timeout_delay: FLUSH after %0d cycles, required 64", k);
    end
    wait_state(S_IDLE, 30);
    n_checks++;
    if (rd_cnt !== 3 || n_out !== 3 || burst_count !== 8'd3 || uf_err !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_reads: reads=%0d out=%0d count=%0d uf_err=%0b, required 3 3 3 0", rd_cnt, n_out, burst_count, uf_err);
    end
  endtask

  task automatic test_backpressure();
    int k;
    clear_stats();
    m_ready = 1'b1;
    push_bytes(16);
    thresh_out = 1'b1;
    tick();
    thresh_out = 1'b0;
    k = 0;
    while (dbg_state !== S_IDLE && k < 300) begin
      m_ready = (k % 4 == 0) || (k % 4 == 3);
      tick();
      k++;
    end
    m_ready = 1'b1;
    n_checks++;
    if (dbg_state !== S_IDLE || rd_cnt !== 16 || n_out !== 16 || exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL backpressure: state=%0d reads=%0d out=%0d pending=%0d, required 0 16 16 0", dbg_state, rd_cnt, n_out, exp_q.size());
    end
    n_checks++;
    if (burst_count !== 8'd4) begin
      n_fail++;
      $display("FAIL backpressure_count: count=%0d, required 4", burst_count);
    end
  endtask

  task automatic test_drain_refill();
    int k;
    clear_stats();
    m_ready = 1'b1;
    push_bytes(5);
    thresh_out = 1'b1;
    tick();
    thresh_out = 1'b0;
    k = 0;
    while (rd_cnt < 5 && k < 40) begin
      tick();
      k++;
    end
    repeat (6) tick();
    n_checks++;
    if (dbg_state !== S_BURST || rd_cnt !== 5 || rd_en !== 1'b0 || n_out !== 5) begin
      n_fail++;
      $display("FAIL drain_pause: state=%0d reads=%0d rd_en=%0b out=%0d, required 1 5 0 5", dbg_state, rd_cnt, rd_en, n_out);
    end
    push_bytes(11);
    wait_state(S_IDLE, 60);
    n_checks++;
    if (dbg_state !== S_IDLE || rd_cnt !== 16 || n_out !== 16 || fifo_q.size() !== 0 || burst_count !== 8'd5) begin
      n_fail++;
      $display("FAIL drain_resume: state=%0d reads=%0d out=%0d fifo=%0d count=%0d, required 0 16 16 0 5", dbg_state, rd_cnt, n_out, fifo_q.size(), burst_count);
    end
  endtask

  task automatic test_random_stream();
    int k;
    clear_stats();
    push_bytes(16);
    thresh_out = 1'b1;
    tick();
    thresh_out = 1'b0;
    k = 0;
    while (dbg_state !== S_IDLE && k < 400) begin
      m_ready = 1'($urandom_range(0, 1));
      tick();
      k++;
    end
    m_ready = 1'b1;
    n_checks++;
    if (dbg_state !== S_IDLE || rd_cnt !== 16 || n_out !== 16 || burst_count !== 8'd6) begin
      n_fail++;
      $display("FAIL random_stream: state=%0d reads=%0d out=%0d count=%0d, required 0 16 16 6", dbg_state, rd_cnt, n_out, burst_count);
    end
  endtask

  task automatic test_underflow_flag();
    n_checks++;
    if (uf_err !== 1'b0) begin
      n_fail++;
      $display("FAIL uf_initial: uf_err=%0b, required 0", uf_err);
    end
    uf_check = 1'b1;
    tick();
    uf_check = 1'b0;
    n_checks++;
    if (uf_err !== 1'b1) begin
      n_fail++;
      $display("FAIL uf_set: uf_err=%0b, required 1", uf_err);
    end
    repeat (10) tick();
    n_checks++;
    if (uf_err !== 1'b1) begin
      n_fail++;
      $display("FAIL uf_sticky: uf_err=%0b, required 1", uf_err);
    end
  endtask

  task automatic test_reset_mid_burst();
    clear_stats();
    m_ready = 1'b0;
    push_bytes(10);
    thresh_out = 1'b1;
    tick();
    thresh_out = 1'b0;
    repeat (4) tick();
    n_checks++;
    if (m_valid !== 1'b1 || dbg_state !== S_BURST || exp_q.size() !== 2) begin
      n_fail++;
      $display("FAIL pre_reset: m_valid=%0b state=%0d held=%0d, required 1 1 2", m_valid, dbg_state, exp_q.size());
    end
    @(negedge clk_r);
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (m_valid !== 1'b0 || rd_en !== 1'b0 || dbg_state !== S_IDLE || burst_active !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_ctrl: m_valid=%0b rd_en=%0b state=%0d active=%0b, required 0 0 0 0", m_valid, rd_en, dbg_state, burst_active);
    end
    n_checks++;
    if (burst_count !== 8'd0 || uf_err !== 1'b0 || m_data !== 8'h00) begin
      n_fail++;
      $display("FAIL async_reset_regs: count=%0d uf_err=%0b m_data=%0h, required 0 0 0", burst_count, uf_err, m_data);
    end
    fifo_q.delete();
    wr_pend.delete();
    exp_q.delete();
    tick();
    tick();
    rst = 1'b1;
    m_ready = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (dbg_state !== S_IDLE || m_valid !== 1'b0 || rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset: state=%0d m_valid=%0b rd_en=%0b, required 0 0 0", dbg_state, m_valid, rd_en);
    end
  endtask

  initial begin
    test_reset();
    test_threshold_burst();
    test_timeout_flush();
    test_backpressure();
    test_drain_refill();
    test_random_stream();
    test_underflow_flag();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_burst_reader.md
# fifo_burst_reader

Read-side consumer for the asynchronous byte FIFO, running entirely in the FIFO's read clock domain. Watches `thresh_out`/`buf_empty`, issues `rd_en` bursts of `BURST_LEN` bytes once the threshold is reached, and flushes stragglers after an idle timeout. Presents the data downstream on a valid/ready stream through a 2-entry output buffer, and never underflows the FIFO.

## Interface
- `DATA_W`, 8, byte width; must match the FIFO `buf_out` width.
- `BURST_LEN`, 16, reads per threshold burst (2..255).
- `TIMEOUT`, 64, idle `clk_r` cycles with a non-empty FIFO below threshold before a flush starts (2..65535).
- `clk_r`  in  1  read-domain clock; the block's only clock.
- `rst`  in  1  asynchronous, active-low reset.
- `buf_out`  in  DATA_W  FIFO read data; valid one cycle after `rd_en`.
- `buf_empty`  in  1  FIFO empty, synchronous to `clk_r`; updates on the same edge that performs a read.
- `thresh_out`  in  1  FIFO occupancy ≥ programmed threshold.
- `uf_check`  in  1  FIFO underflow flag.
- `rd_en`  out  1  FIFO read strobe.
- `m_data`  out  DATA_W  downstream data.
- `m_valid`  out  1  downstream data valid.
- `m_ready`  in  1  downstream accept.
- `burst_active`  out  1  high in BURST, FLUSH and WAIT.
- `burst_count`  out  8  completed bursts and flushes; wraps 255→0.
- `uf_err`  out  1  sticky; set when `uf_check` is sampled high.

## Operation
- States: IDLE, BURST, FLUSH, WAIT.
- IDLE:
  - If `thresh_out` is high → BURST; clear the issue counter.
  - Else if `!buf_empty`, increment `idle_cnt`. At `TIMEOUT-1` → FLUSH.
  - `idle_cnt` clears whenever `buf_empty` is high or the state is not IDLE.
  - `thresh_out` wins over the timeout in the same cycle.
- Issue rule, applied in BURST and FLUSH: `rd_en = !buf_empty && free > 0`.
  - `free = 2 - occ - inflight + (m_valid && m_ready)`.
  - `occ` is the output buffer occupancy (0..2). `inflight` is `rd_en` delayed one cycle.
- BURST: issue reads until `BURST_LEN` have been issued → WAIT. If `buf_empty` goes high mid-burst, pause and stay in BURST.
- FLUSH: issue reads until `buf_empty` is high or `BURST_LEN` have been issued → WAIT.
- WAIT: when `inflight == 0` and `occ == 0` → IDLE; `burst_count` increments on this transition.
- Data capture: the cycle after `rd_en`, `buf_out` is written into the output buffer. Data is never dropped or duplicated; downstream order equals FIFO order.
- `uf_err` is cleared only by reset.

## Timing
- Reset values: `rd_en` 0, `m_valid` 0, `m_data` 0, `burst_active` 0, `burst_count` 0, `uf_err` 0; state IDLE; all counters 0.
- Latency: `thresh_out` high at edge n → state BURST at n+1 → first `rd_en` during cycle n+1 → `m_valid` at n+3.
- Throughput: with `m_ready` held high, one byte per cycle. A `BURST_LEN` burst occupies `BURST_LEN + 2` cycles from the first `rd_en` until `m_valid` drops.
- Backpressure: `m_ready` low holds `m_data`/`m_valid` stable. At most 2 bytes are buffered; `rd_en` stops so that `occ + inflight` never exceeds 2.
- Simultaneous push and pop on the buffer in the same cycle: both take effect, and `occ` is unchanged.
- Reset mid-operation: in-flight and buffered bytes are discarded; outputs return to their reset values immediately (asynchronously).

## Structure
- Package `fifo_rd_pkg`: state enum (2-bit: IDLE=0, BURST=1, FLUSH=2, WAIT=3) and the `DATA_W` default.
- Sub-module `out_skid_buf`: 2-entry valid/ready buffer with push, pop and `occ` outputs.
- Top level holds the FSM, the issue counter, `idle_cnt` and `burst_count`.

## Test plan
- `thresh_out` held high, FIFO holds 20 bytes, `m_ready`=1 → exactly 16 `rd_en` pulses back-to-back; 16 bytes out in FIFO order; `burst_count` 0→1.
- FIFO holds 3 bytes, `thresh_out`=0, `TIMEOUT`=64 → FLUSH entered 64 cycles after `buf_empty` fell; 3 reads issued, never with `buf_empty` high; `uf_err` stays 0.
- BURST with `m_ready` toggling 1,0,0,1 repeatedly → `occ + inflight` never exceeds 2; no byte lost or duplicated over 16 beats.
- FIFO drains to empty after 5 reads of a 16-byte burst, then refills → `rd_en` pauses while empty and resumes; the burst completes at 16 total reads.
- `rst` asserted low mid-burst with 2 bytes buffered → `m_valid` 0 and `rd_en` 0 immediately; state IDLE; `burst_count` 0.
- `uf_check` pulsed for 1 cycle → `uf_err` stays 1 until `rst`.
